// File: rtl/mac_window_feeder_pkg.sv
// Shared types and constants for the MAC window feeder and its coefficient bank.
package mac_window_feeder_pkg;

    localparam int FP_W      = 32;
    localparam int KSIZE_DEF = 9;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // LSB position of tap i inside a packed window of dw-bit pixels.
    function automatic int unsigned tap_lsb(input int unsigned tap, input int unsigned dw);
        return tap * dw;
    endfunction

endpackage

// File: rtl/mac_coeff_bank.sv
// KSIZE x DW kernel coefficient registers with busy/range write gating,
// a one-cycle drop pulse and a combinational read with write forwarding.
module mac_coeff_bank
    import mac_window_feeder_pkg::*;
#(
    parameter int KSIZE = KSIZE_DEF,
    parameter int DW    = FP_W,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          busy,
    input  logic [AW-1:0] rd_tap,
    output logic [DW-1:0] rd_data,
    output logic          drop
);

    localparam logic [AW:0] KSIZE_W = (AW + 1)'(KSIZE);

    logic [DW-1:0] coeff_q [KSIZE];
    logic          wr_ok;

    assign wr_ok = we && !busy && ({1'b0, addr} < KSIZE_W);

    // A write landing on the tap being loaded this edge must be seen by that load.
    assign rd_data = (wr_ok && (addr == rd_tap)) ? data : coeff_q[rd_tap];

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the bank must read back as zero after reset, so every entry
            // is cleared explicitly instead of being treated as uninitialised RAM.
            for (int i = 0; i < KSIZE; i++) begin
                coeff_q[i] <= '0;
            end
            drop <= 1'b0;
        end else begin
            if (wr_ok) begin
                coeff_q[addr] <= data;
            end
            drop <= we && !wr_ok;
        end
    end

endmodule

// File: rtl/mac_window_feeder.sv
// Serialises one KSIZE-pixel window into (pixel, coefficient) beats for the MAC.
// Optional MAC_FEEDER_PINGPONG_EN adds a spare window buffer for back-to-back streaming.
module mac_window_feeder
    import mac_window_feeder_pkg::*;
#(
    parameter int KSIZE = KSIZE_DEF,
    parameter int DW    = FP_W,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_window_valid,
    output logic                ou_window_ready,
    input  logic [KSIZE*DW-1:0] in_window,
    input  logic                in_window_last_pixel,
    input  logic                in_coeff_we,
    input  logic [AW-1:0]       in_coeff_addr,
    input  logic [DW-1:0]       in_coeff_data,
    output logic                ou_coeff_drop,
    output logic                ou_data_valid,
    input  logic                in_data_ready,
    output logic [DW-1:0]       ou_grayscale_fp,
    output logic [DW-1:0]       ou_kernel_coeff,
    output logic                ou_data_last,
    output logic                ou_last_pixel,
    output logic                ou_busy
);

    localparam logic [AW-1:0] LAST_TAP = AW'(KSIZE - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         tap_q, tap_d;
    logic [KSIZE*DW-1:0]   win_q, win_d;
    logic                  lp_q, lp_d;
`ifdef MAC_FEEDER_PINGPONG_EN
    logic [KSIZE*DW-1:0]   spare_win_q, spare_win_d;
    logic                  spare_lp_q, spare_lp_d;
    logic                  spare_full_q, spare_full_d;
`endif

    logic                  accept, xfer, load, load_lp;
    logic [AW-1:0]         load_tap;
    logic [KSIZE*DW-1:0]   load_win;
    logic [DW-1:0]         coeff_rd, gray_d;
    logic                  ready_d, valid_d, busy_d, last_d, lastpix_d;

    mac_coeff_bank #(.KSIZE(KSIZE), .DW(DW), .AW(AW)) u_coeff_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (in_coeff_we),
        .addr    (in_coeff_addr),
        .data    (in_coeff_data),
        .busy    (ou_busy),
        .rd_tap  (load_tap),
        .rd_data (coeff_rd),
        .drop    (ou_coeff_drop)
    );

    always_comb begin
        // NOTE: every next-state variable starts from its current value, so no
        // branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        tap_d     = tap_q;
        win_d     = win_q;
        lp_d      = lp_q;
        valid_d   = ou_data_valid;
        busy_d    = ou_busy;
        last_d    = ou_data_last;
        lastpix_d = ou_last_pixel;
        gray_d    = ou_grayscale_fp;
        load      = 1'b0;
        load_tap  = '0;
        load_win  = win_q;
        load_lp   = lp_q;
        accept    = in_window_valid && ou_window_ready;
        xfer      = ou_data_valid && in_data_ready;
`ifdef MAC_FEEDER_PINGPONG_EN
        spare_win_d  = spare_win_q;
        spare_lp_d   = spare_lp_q;
        spare_full_d = spare_full_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = STREAM;
                    load     = 1'b1;
                    load_win = in_window;
                    load_lp  = in_window_last_pixel;
                end
            end
            STREAM: begin
                if (xfer && (tap_q == LAST_TAP)) begin
`ifdef MAC_FEEDER_PINGPONG_EN
                    if (spare_full_q) begin
                        load         = 1'b1;
                        load_win     = spare_win_q;
                        load_lp      = spare_lp_q;
                        spare_full_d = 1'b0;
                    end else if (accept) begin
                        load     = 1'b1;
                        load_win = in_window;
                        load_lp  = in_window_last_pixel;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (xfer) begin
                    load     = 1'b1;
                    load_tap = tap_q + 1'b1;
                end
`ifdef MAC_FEEDER_PINGPONG_EN
                // Park the incoming window unless it was taken straight into streaming.
                if (accept && !(xfer && (tap_q == LAST_TAP) && !spare_full_q)) begin
                    spare_win_d  = in_window;
                    spare_lp_d   = in_window_last_pixel;
                    spare_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            tap_d     = load_tap;
            win_d     = load_win;
            lp_d      = load_lp;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            last_d    = (load_tap == LAST_TAP);
            lastpix_d = load_lp;
            gray_d    = load_win[tap_lsb(32'(load_tap), DW) +: DW];
        end else if (state_d == IDLE) begin
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            last_d    = 1'b0;
            lastpix_d = 1'b0;
        end

`ifdef MAC_FEEDER_PINGPONG_EN
        ready_d = (state_d == IDLE) || !spare_full_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            tap_q           <= '0;
            ou_window_ready <= 1'b0;
            ou_data_valid   <= 1'b0;
            ou_busy         <= 1'b0;
            ou_data_last    <= 1'b0;
            ou_last_pixel   <= 1'b0;
            ou_grayscale_fp <= '0;
            ou_kernel_coeff <= '0;
`ifdef MAC_FEEDER_PINGPONG_EN
            spare_full_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            tap_q           <= tap_d;
            ou_window_ready <= ready_d;
            ou_data_valid   <= valid_d;
            ou_busy         <= busy_d;
            ou_data_last    <= last_d;
            ou_last_pixel   <= lastpix_d;
            ou_grayscale_fp <= gray_d;
            if (load) begin
                ou_kernel_coeff <= coeff_rd;
            end
`ifdef MAC_FEEDER_PINGPONG_EN
            spare_full_q    <= spare_full_d;
`endif
        end
    end

    // NOTE: window buffers carry no reset; they are only ever read behind valid state.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        lp_q  <= lp_d;
`ifdef MAC_FEEDER_PINGPONG_EN
        spare_win_q <= spare_win_d;
        spare_lp_q  <= spare_lp_d;
`endif
    end

endmodule

// File: tb/tb_mac_window_feeder.sv
// Directed bench for mac_window_feeder: streaming order, stalls, flags,
// coefficient write gating, mid-stream reset and (optionally) ping-pong.
module tb_mac_window_feeder;
    import mac_window_feeder_pkg::*;

    localparam int KSIZE = 9;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int WW    = KSIZE * DW;
`ifdef MAC_FEEDER_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_window_valid = 1'b0;
    logic          ou_window_ready;
    logic [WW-1:0] in_window = '0;
    logic          in_window_last_pixel = 1'b0;
    logic          in_coeff_we = 1'b0;
    logic [AW-1:0] in_coeff_addr = '0;
    logic [DW-1:0] in_coeff_data = '0;
    logic          ou_coeff_drop;
    logic          ou_data_valid;
    logic          in_data_ready = 1'b0;
    logic [DW-1:0] ou_grayscale_fp;
    logic [DW-1:0] ou_kernel_coeff;
    logic          ou_data_last;
    logic          ou_last_pixel;
    logic          ou_busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] coef_model [KSIZE];

    mac_window_feeder #(.KSIZE(KSIZE), .DW(DW), .AW(AW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_window_valid      (in_window_valid),
        .ou_window_ready      (ou_window_ready),
        .in_window            (in_window),
        .in_window_last_pixel (in_window_last_pixel),
        .in_coeff_we          (in_coeff_we),
        .in_coeff_addr        (in_coeff_addr),
        .in_coeff_data        (in_coeff_data),
        .ou_coeff_drop        (ou_coeff_drop),
        .ou_data_valid        (ou_data_valid),
        .in_data_ready        (in_data_ready),
        .ou_grayscale_fp      (ou_grayscale_fp),
        .ou_kernel_coeff      (ou_kernel_coeff),
        .ou_data_last         (ou_data_last),
        .ou_last_pixel        (ou_last_pixel),
        .ou_busy              (ou_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] make_win(input logic [DW-1:0] base, input logic [DW-1:0] step);
        logic [WW-1:0] w;
        for (int i = 0; i < KSIZE; i++) begin
            w[i*DW +: DW] = base + step * DW'(i);
        end
        return w;
    endfunction

    task automatic check_beat(input string tag, input int b, input logic [WW-1:0] win, input logic lp);
        logic [DW-1:0] ref_pix;
        ref_pix = win[b*DW +: DW];
        check($sformatf("%s valid b%0d", tag, b), ou_data_valid, 1);
        check($sformatf("%s busy b%0d", tag, b), ou_busy, 1);
        check($sformatf("%s pixel b%0d", tag, b), ou_grayscale_fp, ref_pix);
        check($sformatf("%s coeff b%0d", tag, b), ou_kernel_coeff, coef_model[b]);
        check($sformatf("%s last b%0d", tag, b), ou_data_last, (b == KSIZE - 1) ? 1 : 0);
        check($sformatf("%s lastpix b%0d", tag, b), ou_last_pixel, lp);
        check($sformatf("%s ready b%0d", tag, b), ou_window_ready, PP);
    endtask

    task automatic write_coeff(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic exp_drop);
        in_coeff_we   = 1'b1;
        in_coeff_addr = addr;
        in_coeff_data = data;
        @(negedge clk);
        in_coeff_we = 1'b0;
        check($sformatf("drop wr a%0d", addr), ou_coeff_drop, exp_drop);
        if (!exp_drop) coef_model[addr] = data;
        @(negedge clk);
        check($sformatf("drop clear a%0d", addr), ou_coeff_drop, 0);
    endtask

    // Presents one window at a negedge and checks every beat; optional stall,
    // write at acceptance, write during streaming, or reset at a chosen beat.
    task automatic run_window(input string tag, input logic [WW-1:0] win, input logic lp,
                              input int stall_beat, input logic acc_wr, input logic mid_wr,
                              input logic [AW-1:0] wr_addr, input logic [DW-1:0] wr_data,
                              input int rst_beat);
        int cyc;
        check({tag, " ready idle"}, ou_window_ready, 1);
        in_window            = win;
        in_window_valid      = 1'b1;
        in_window_last_pixel = lp;
        in_data_ready        = 1'b1;
        if (acc_wr) begin
            in_coeff_we   = 1'b1;
            in_coeff_addr = wr_addr;
            in_coeff_data = wr_data;
            coef_model[wr_addr] = wr_data;
        end
        @(negedge clk);
        cyc = 1;
        in_window_valid = 1'b0;
        for (int b = 0; b < KSIZE; b++) begin
            check_beat(tag, b, win, lp);
            check($sformatf("%s drop b%0d", tag, b), ou_coeff_drop, (mid_wr && b == 3) ? 1 : 0);
            in_coeff_we = mid_wr && (b == 2);
            if (in_coeff_we) begin
                in_coeff_addr = wr_addr;
                in_coeff_data = wr_data;
            end
            if (b == rst_beat) begin
                rst = 1'b0;
                @(negedge clk);
                check({tag, " rst ready"}, ou_window_ready, 0);
                check({tag, " rst valid"}, ou_data_valid, 0);
                check({tag, " rst busy"}, ou_busy, 0);
                check({tag, " rst last"}, ou_data_last, 0);
                check({tag, " rst lastpix"}, ou_last_pixel, 0);
                check({tag, " rst pixel"}, ou_grayscale_fp, 0);
                check({tag, " rst coeff"}, ou_kernel_coeff, 0);
                check({tag, " rst drop"}, ou_coeff_drop, 0);
                for (int i = 0; i < KSIZE; i++) coef_model[i] = '0;
                rst = 1'b1;
                @(negedge clk);
                check({tag, " post-rst ready"}, ou_window_ready, 1);
                check({tag, " post-rst valid"}, ou_data_valid, 0);
                return;
            end
            if (b == stall_beat) begin
                in_data_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    cyc++;
                    check_beat({tag, " stall"}, b, win, lp);
                end
                in_data_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " end valid"}, ou_data_valid, 0);
        check({tag, " end busy"}, ou_busy, 0);
        check({tag, " end last"}, ou_data_last, 0);
        check({tag, " end ready"}, ou_window_ready, 1);
        check({tag, " period"}, DW'(cyc), DW'(KSIZE + 1 + ((stall_beat >= 0) ? 2 : 0)));
    endtask

    initial begin
        logic [WW-1:0] win_a;
        logic [WW-1:0] win_b;
        for (int i = 0; i < KSIZE; i++) coef_model[i] = '0;

        repeat (2) @(negedge clk);
        check("reset ready", ou_window_ready, 0);
        check("reset valid", ou_data_valid, 0);
        check("reset busy", ou_busy, 0);
        check("reset pixel", ou_grayscale_fp, 0);
        check("reset coeff", ou_kernel_coeff, 0);
        check("reset last", ou_data_last, 0);
        check("reset lastpix", ou_last_pixel, 0);
        check("reset drop", ou_coeff_drop, 0);
        rst = 1'b1;
        @(negedge clk);
        check("release ready", ou_window_ready, 1);

        // fp32 1.0 .. 9.0
        write_coeff(4'd0, 32'h3F80_0000, 1'b0);
        write_coeff(4'd1, 32'h4000_0000, 1'b0);
        write_coeff(4'd2, 32'h4040_0000, 1'b0);
        write_coeff(4'd3, 32'h4080_0000, 1'b0);
        write_coeff(4'd4, 32'h40A0_0000, 1'b0);
        write_coeff(4'd5, 32'h40C0_0000, 1'b0);
        write_coeff(4'd6, 32'h40E0_0000, 1'b0);
        write_coeff(4'd7, 32'h4100_0000, 1'b0);
        write_coeff(4'd8, 32'h4110_0000, 1'b0);

        run_window("w1", make_win(32'h4000_0000, 32'd0), 1'b0, -1, 1'b0, 1'b0, '0, '0, -1);
        run_window("w2", make_win(32'h1000_0000, 32'd1), 1'b0, 4, 1'b1, 1'b0, 4'd0, 32'h4120_0000, -1);
        run_window("w3", make_win(32'h2000_0000, 32'd3), 1'b1, -1, 1'b0, 1'b1, 4'd1, 32'hDEAD_BEEF, -1);
        write_coeff(4'd12, 32'h1234_5678, 1'b1);
        run_window("w4", make_win(32'h3000_0000, 32'd5), 1'b0, -1, 1'b0, 1'b0, '0, '0, -1);
        run_window("w5", make_win(32'h5000_0000, 32'd7), 1'b1, -1, 1'b0, 1'b0, '0, '0, 5);
        run_window("w6", make_win(32'h6000_0000, 32'd2), 1'b0, -1, 1'b0, 1'b0, '0, '0, -1);

`ifdef MAC_FEEDER_PINGPONG_EN
        win_a = make_win(32'h7000_0000, 32'd1);
        win_b = make_win(32'h7100_0000, 32'd1);
        check("pp ready idle", ou_window_ready, 1);
        in_window            = win_a;
        in_window_last_pixel = 1'b0;
        in_window_valid      = 1'b1;
        in_data_ready        = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2 * KSIZE; k++) begin
            check($sformatf("pp valid k%0d", k), ou_data_valid, 1);
            check($sformatf("pp busy k%0d", k), ou_busy, 1);
            check($sformatf("pp pixel k%0d", k), ou_grayscale_fp,
                  (k < KSIZE) ? win_a[k*DW +: DW] : win_b[(k-KSIZE)*DW +: DW]);
            check($sformatf("pp last k%0d", k), ou_data_last,
                  (k == KSIZE - 1 || k == 2 * KSIZE - 1) ? 1 : 0);
            check($sformatf("pp lastpix k%0d", k), ou_last_pixel, (k >= KSIZE) ? 1 : 0);
            if (k == 0) begin
                check("pp ready spare empty", ou_window_ready, 1);
                in_window            = win_b;
                in_window_last_pixel = 1'b1;
            end else if (k == 1) begin
                check("pp ready spare full", ou_window_ready, 0);
                in_window_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("pp end valid", ou_data_valid, 0);
        check("pp end busy", ou_busy, 0);
`else
        win_a = '0;
        win_b = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
